fifo_banco_rr: RTL and testbench
================================

# fifo_banco_rr

Parametrised multi-channel FIFO bank: NUM_CH independent FIFOs behind one write port, drained through one read port by a round-robin arbiter that tags each output word with its source channel. Per-channel full/empty, programmable almost-full/almost-empty and sticky overflow flags. It is the next generation of the single-channel FIFO memory and sits between the per-lane producers and the shared downstream consumer.

## Interface
- NUM_CH, 4: number of channels (power of 2, ≥2)
- CH_L, 2: channel-index width, log2(NUM_CH)
- MEM_SIZE, 4: entries per channel (power of 2)
- WORD_SIZE, 6: data width
- PTR_L, 3: count/threshold width, log2(MEM_SIZE)+1

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- wr_ch  in  CH_L  target channel of the write
- data_in  in  WORD_SIZE  write data
- rd_en  in  1  consumer requests one word this cycle
- empty_threshold  in  PTR_L  almost-empty level, shared by all channels
- full_threshold  in  PTR_L  almost-full level, shared; 0 disables almost_full
- data_out  out  WORD_SIZE  popped word, registered
- data_out_ch  out  CH_L  source channel of data_out
- valid_out  out  1  data_out/data_out_ch valid this cycle
- fifo_full  out  NUM_CH  bit i: count[i] == MEM_SIZE
- fifo_empty  out  NUM_CH  bit i: count[i] == 0
- almost_full  out  NUM_CH  bit i: full_threshold != 0 and count[i] ≥ full_threshold
- almost_empty  out  NUM_CH  bit i: count[i] ≤ empty_threshold
- error  out  NUM_CH  bit i: sticky overflow on channel i

## Operation
- Per-channel state: circular storage, wr_ptr/rd_ptr (log2(MEM_SIZE) bits, natural wrap), count (PTR_L bits, 0..MEM_SIZE).
- Write: on wr_en, if fifo_full[wr_ch] is 0 (pre-edge value), store data_in at wr_ptr, advance wr_ptr, count+1. If full: word dropped, error[wr_ch] set to 1, no state change.
- Read: on rd_en, arbiter searches channels rr_ptr+1, rr_ptr+2, … (mod NUM_CH) for the first with fifo_empty 0 (pre-edge). On grant: that channel's head word goes to data_out, channel to data_out_ch, valid_out=1, rd_ptr advances, count−1, rr_ptr ← granted channel.
- rd_en with all channels empty, or rd_en=0: valid_out=0; data_out/data_out_ch hold previous value; rr_ptr unchanged; no error (underflow impossible by construction).
- Write and grant on the same channel in one cycle: both happen, count unchanged. Write into a full channel that is also granted that cycle is still dropped with error set (full is evaluated pre-edge).
- Write into an empty channel: not eligible for the same-cycle grant; eligible from the next cycle.
- Flags are combinational decodes of the count registers and threshold inputs; threshold changes take effect immediately.
- error bits clear only on reset.

## Timing
- Write-to-flag latency: 1 cycle (count register updates at the edge).
- Read latency: 1 cycle; rd_en sampled at edge N, data_out/valid_out valid after edge N, for one cycle per grant.
- Sustained throughput: 1 write and 1 read per cycle.
- Reset (synchronous, any time, including mid-transfer): all counts/pointers 0, stored data discarded, rr_ptr = NUM_CH−1 (channel 0 searched first), data_out 0, data_out_ch 0, valid_out 0, error 0, fifo_empty all 1, fifo_full 0, almost_empty all 1, almost_full 0 for any full_threshold (count 0, threshold 0 disables it). wr_en/rd_en ignored in the reset cycle.

## Structure
- Shared package/header: default parameter values, derived widths (CH_L, PTR_L from NUM_CH, MEM_SIZE).
- Sub-module fifo_canal: one channel's storage, pointers, count, full/empty/almost/error logic; instantiated NUM_CH times via generate. Round-robin arbiter and output register live in the top.

## Test plan
- Reset 5 cycles, then idle -> fifo_empty=4'b1111, almost_empty=4'b1111, valid_out=0, error=0, data_out=0.
- Write 4 words 0x11..0x14 to ch2, fifo_full[2]=1; 5th write 0x15 -> dropped, error=4'b0100; drain with rd_en -> outputs 0x11..0x14 tagged ch2, then valid_out=0.
- Load one word in each of ch0..ch3 (0x01,0x02,0x03,0x04), then rd_en held 5 cycles -> outputs ch0,ch1,ch2,ch3 in order, 5th cycle valid_out=0.
- ch1 and ch3 each hold 3 words, rd_en held -> grants alternate 1,3,1,3,1,3.
- full_threshold=3, empty_threshold=1, ch0: write 3 words -> almost_full[0]=1 after 3rd; simultaneous write+read for 4 cycles -> count stays 3, no error; read to 1 word -> almost_empty[0]=1.
- Reset asserted mid-stream with ch0 at 3 words and rd_en=1 -> next cycle all channels empty, valid_out=0, error cleared, first later grant comes from ch0.

Source files
------------

// File: rtl/fifo_banco_rr_pkg.sv
// Shared defaults and derived widths for the multi-channel FIFO bank.
package fifo_banco_rr_pkg;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_MEM_SIZE  = 4;
    localparam int unsigned DEF_WORD_SIZE = 6;
    localparam int unsigned DEF_CH_L      = $clog2(DEF_NUM_CH);
    localparam int unsigned DEF_PTR_L     = $clog2(DEF_MEM_SIZE) + 1;

endpackage

// File: rtl/fifo_canal.sv
// One FIFO channel: circular storage, pointers, occupancy count, status flags and sticky overflow.
module fifo_canal
    import fifo_banco_rr_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned PTR_L     = DEF_PTR_L
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_en,
    input  logic [PTR_L-1:0]     empty_threshold,
    input  logic [PTR_L-1:0]     full_threshold,
    output logic [WORD_SIZE-1:0] head_c,
    output logic                 full_c,
    output logic                 empty_c,
    output logic                 almost_full_c,
    output logic                 almost_empty_c,
    output logic                 error
);

    localparam int unsigned AW = PTR_L - 1;

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [PTR_L-1:0]     count;
    logic                 wr_ok;

    // Full is judged on the pre-edge count, so a write into a full channel drops even if it is read this cycle.
    assign wr_ok = wr_en && !full_c;

    assign head_c         = mem[rd_ptr];
    assign full_c         = (count == PTR_L'(MEM_SIZE));
    assign empty_c        = (count == '0);
    assign almost_full_c  = (full_threshold != '0) && (count >= full_threshold);
    assign almost_empty_c = (count <= empty_threshold);

    // Storage needs no reset; pointers and count define what is readable.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_en})
                2'b10:   count <= count + PTR_L'(1);
                2'b01:   count <= count - PTR_L'(1);
                default: count <= count;
            endcase
            if (wr_en && full_c) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_banco_rr.sv
// Multi-channel FIFO bank: one write port, one round-robin arbitrated read port with channel tag.
module fifo_banco_rr
    import fifo_banco_rr_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned CH_L      = DEF_CH_L,
    parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned PTR_L     = DEF_PTR_L
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CH_L-1:0]      wr_ch,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_en,
    input  logic [PTR_L-1:0]     empty_threshold,
    input  logic [PTR_L-1:0]     full_threshold,
    output logic [WORD_SIZE-1:0] data_out,
    output logic [CH_L-1:0]      data_out_ch,
    output logic                 valid_out,
    output logic [NUM_CH-1:0]    fifo_full,
    output logic [NUM_CH-1:0]    fifo_empty,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH-1:0]    almost_empty,
    output logic [NUM_CH-1:0]    error
);

    logic [WORD_SIZE-1:0] head [NUM_CH];
    logic [CH_L-1:0]      rr_ptr;
    logic [CH_L-1:0]      gnt_ch;
    logic                 gnt_found;
    logic [NUM_CH-1:0]    gnt_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fifo_canal #(
            .MEM_SIZE  (MEM_SIZE),
            .WORD_SIZE (WORD_SIZE),
            .PTR_L     (PTR_L)
        ) u_canal (
            .clk             (clk),
            .reset           (reset),
            .wr_en           (wr_en && (wr_ch == CH_L'(i))),
            .data_in         (data_in),
            .rd_en           (gnt_vec[i]),
            .empty_threshold (empty_threshold),
            .full_threshold  (full_threshold),
            .head_c          (head[i]),
            .full_c          (fifo_full[i]),
            .empty_c         (fifo_empty[i]),
            .almost_full_c   (almost_full[i]),
            .almost_empty_c  (almost_empty[i]),
            .error           (error[i])
        );
    end

    // Round-robin search starting just after the last granted channel; rr_ptr itself is tried last.
    always_comb begin
        logic [CH_L-1:0] idx;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        gnt_vec   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = rr_ptr + CH_L'(k);
            if (rd_en && !gnt_found && !fifo_empty[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx;
            end
        end
        if (gnt_found) begin
            gnt_vec[gnt_ch] = 1'b1;
        end
    end

    // Output register; data and tag hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= CH_L'(NUM_CH - 1);
            data_out    <= '0;
            data_out_ch <= '0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= gnt_found;
            if (gnt_found) begin
                data_out    <= head[gnt_ch];
                data_out_ch <= gnt_ch;
                rr_ptr      <= gnt_ch;
            end
        end
    end

endmodule

// File: tb/tb_fifo_banco_rr.sv
// Directed self-checking bench for fifo_banco_rr with hand-computed expectations.
module tb_fifo_banco_rr;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [5:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [2:0] empty_threshold = '0;
    logic [2:0] full_threshold = '0;
    logic [5:0] data_out;
    logic [1:0] data_out_ch;
    logic       valid_out;
    logic [3:0] fifo_full;
    logic [3:0] fifo_empty;
    logic [3:0] almost_full;
    logic [3:0] almost_empty;
    logic [3:0] error;

    int n_checks = 0;
    int n_errors = 0;

    fifo_banco_rr dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_ch           (wr_ch),
        .data_in         (data_in),
        .rd_en           (rd_en),
        .empty_threshold (empty_threshold),
        .full_threshold  (full_threshold),
        .data_out        (data_out),
        .data_out_ch     (data_out_ch),
        .valid_out       (valid_out),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [1:0] ch, input logic [5:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        data_in = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (fifo_empty !== 4'b1111) begin n_errors++; $display("FAIL reset_fifo_empty: got %b expected 1111", fifo_empty); end
        n_checks++; if (almost_empty !== 4'b1111) begin n_errors++; $display("FAIL reset_almost_empty: got %b expected 1111", almost_empty); end
        n_checks++; if (fifo_full !== 4'b0000) begin n_errors++; $display("FAIL reset_fifo_full: got %b expected 0000", fifo_full); end
        n_checks++; if (almost_full !== 4'b0000) begin n_errors++; $display("FAIL reset_almost_full: got %b expected 0000", almost_full); end
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        n_checks++; if (error !== 4'b0000) begin n_errors++; $display("FAIL reset_error: got %b expected 0000", error); end
        n_checks++; if (data_out !== 6'h00 || data_out_ch !== 2'd0) begin n_errors++; $display("FAIL reset_data: got %h/%0d expected 00/0", data_out, data_out_ch); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) write_word(2'd2, 6'(8'h11 + i));
        n_checks++; if (fifo_full !== 4'b0100) begin n_errors++; $display("FAIL ovf_full: got %b expected 0100", fifo_full); end
        n_checks++; if (fifo_empty !== 4'b1011) begin n_errors++; $display("FAIL ovf_empty: got %b expected 1011", fifo_empty); end
        write_word(2'd2, 6'h15);
        n_checks++; if (error !== 4'b0100) begin n_errors++; $display("FAIL ovf_error: got %b expected 0100", error); end
        n_checks++; if (fifo_full !== 4'b0100) begin n_errors++; $display("FAIL ovf_still_full: got %b expected 0100", fifo_full); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 6'(8'h11 + i) || data_out_ch !== 2'd2) begin
                n_errors++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=2", i, valid_out, data_out, data_out_ch, 6'(8'h11 + i));
            end
        end
        tick();
        n_checks++; if (valid_out !== 1'b0 || data_out !== 6'h14) begin n_errors++; $display("FAIL ovf_drained: got v=%b d=%h expected v=0 d=14", valid_out, data_out); end
        n_checks++; if (fifo_empty !== 4'b1111) begin n_errors++; $display("FAIL ovf_empty_after: got %b expected 1111", fifo_empty); end
        rd_en = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) write_word(2'(i), 6'(i + 1));
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 6'(i + 1) || data_out_ch !== 2'(i)) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d", i, valid_out, data_out, data_out_ch, 6'(i + 1), i);
            end
        end
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL rr_idle: got v=%b expected 0", valid_out); end
        rd_en = 1'b0;
    endtask

    task automatic test_alternate();
        logic [1:0] ech;
        logic [5:0] ed;
        for (int i = 0; i < 3; i++) begin
            write_word(2'd1, 6'(8'h21 + i));
            write_word(2'd3, 6'(8'h31 + i));
        end
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ech = (i % 2 == 1) ? 2'd3 : 2'd1;
            ed  = (i % 2 == 1) ? 6'(8'h31 + i / 2) : 6'(8'h21 + i / 2);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== ed || data_out_ch !== ech) begin
                n_errors++;
                $display("FAIL alt_grant%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d", i, valid_out, data_out, data_out_ch, ed, ech);
            end
        end
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL alt_idle: got v=%b expected 0", valid_out); end
        rd_en = 1'b0;
    endtask

    task automatic test_thresholds();
        do_reset();
        full_threshold  = 3'd3;
        empty_threshold = 3'd1;
        write_word(2'd0, 6'h0A);
        n_checks++; if (almost_empty !== 4'b1111 || almost_full !== 4'b0000) begin n_errors++; $display("FAIL thr_one: got ae=%b af=%b expected ae=1111 af=0000", almost_empty, almost_full); end
        write_word(2'd0, 6'h0B);
        n_checks++; if (almost_empty !== 4'b1110 || almost_full !== 4'b0000) begin n_errors++; $display("FAIL thr_two: got ae=%b af=%b expected ae=1110 af=0000", almost_empty, almost_full); end
        write_word(2'd0, 6'h0C);
        n_checks++; if (almost_full !== 4'b0001) begin n_errors++; $display("FAIL thr_three: got af=%b expected 0001", almost_full); end
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_ch = 2'd0; data_in = 6'(8'h0D + i); rd_en = 1'b1;
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 6'(8'h0A + i) || almost_full !== 4'b0001 || fifo_full !== 4'b0000 || error !== 4'b0000) begin
                n_errors++;
                $display("FAIL thr_wr_rd%0d: got v=%b d=%h af=%b ff=%b err=%b expected v=1 d=%h af=0001 ff=0000 err=0000",
                         i, valid_out, data_out, almost_full, fifo_full, error, 6'(8'h0A + i));
            end
        end
        wr_en = 1'b0;
        tick();
        n_checks++; if (data_out !== 6'h0E || almost_empty !== 4'b1110) begin n_errors++; $display("FAIL thr_read_two: got d=%h ae=%b expected d=0e ae=1110", data_out, almost_empty); end
        tick();
        n_checks++; if (data_out !== 6'h0F || almost_empty !== 4'b1111) begin n_errors++; $display("FAIL thr_read_one: got d=%h ae=%b expected d=0f ae=1111", data_out, almost_empty); end
        rd_en = 1'b0;
        empty_threshold = 3'd0;
        #1;
        n_checks++; if (almost_empty !== 4'b1110) begin n_errors++; $display("FAIL thr_et_change: got %b expected 1110", almost_empty); end
        full_threshold = 3'd1;
        #1;
        n_checks++; if (almost_full !== 4'b0001) begin n_errors++; $display("FAIL thr_ft_one: got %b expected 0001", almost_full); end
        full_threshold = 3'd0;
        #1;
        n_checks++; if (almost_full !== 4'b0000) begin n_errors++; $display("FAIL thr_ft_zero: got %b expected 0000", almost_full); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        rd_en = 1'b1;
        write_word(2'd2, 6'h2A);
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL sc_no_bypass: got v=%b expected 0", valid_out); end
        tick();
        n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h2A || data_out_ch !== 2'd2) begin n_errors++; $display("FAIL sc_next: got v=%b d=%h ch=%0d expected v=1 d=2a ch=2", valid_out, data_out, data_out_ch); end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) write_word(2'd3, 6'(8'h30 + i));
        n_checks++; if (fifo_full !== 4'b1000) begin n_errors++; $display("FAIL sc_full: got %b expected 1000", fifo_full); end
        wr_en = 1'b1; wr_ch = 2'd3; data_in = 6'h3F; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 6'h30 || data_out_ch !== 2'd3 || error !== 4'b1000 || fifo_full !== 4'b0000) begin
            n_errors++;
            $display("FAIL sc_full_grant: got v=%b d=%h ch=%0d err=%b ff=%b expected v=1 d=30 ch=3 err=1000 ff=0000",
                     valid_out, data_out, data_out_ch, error, fifo_full);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 6'(8'h30 + i)) begin
                n_errors++;
                $display("FAIL sc_drain%0d: got v=%b d=%h expected v=1 d=%h", i, valid_out, data_out, 6'(8'h30 + i));
            end
        end
        tick();
        n_checks++; if (valid_out !== 1'b0 || error !== 4'b1000) begin n_errors++; $display("FAIL sc_dropped: got v=%b err=%b expected v=0 err=1000", valid_out, error); end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) write_word(2'd1, 6'(8'h01 + i));
        for (int i = 0; i < 3; i++) write_word(2'd0, 6'(8'h21 + i));
        n_checks++; if (error !== 4'b0010) begin n_errors++; $display("FAIL rm_pre_error: got %b expected 0010", error); end
        reset = 1'b1; rd_en = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; data_in = 6'h3C;
        tick();
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (fifo_empty !== 4'b1111 || valid_out !== 1'b0 || error !== 4'b0000 || data_out !== 6'h00 || data_out_ch !== 2'd0) begin
            n_errors++;
            $display("FAIL rm_after: got fe=%b v=%b err=%b d=%h ch=%0d expected fe=1111 v=0 err=0000 d=00 ch=0",
                     fifo_empty, valid_out, error, data_out, data_out_ch);
        end
        write_word(2'd3, 6'h03);
        write_word(2'd0, 6'h05);
        rd_en = 1'b1;
        tick();
        n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h05 || data_out_ch !== 2'd0) begin n_errors++; $display("FAIL rm_first: got v=%b d=%h ch=%0d expected v=1 d=05 ch=0", valid_out, data_out, data_out_ch); end
        tick();
        n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h03 || data_out_ch !== 2'd3) begin n_errors++; $display("FAIL rm_second: got v=%b d=%h ch=%0d expected v=1 d=03 ch=3", valid_out, data_out, data_out_ch); end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_round_robin();
        test_alternate();
        test_thresholds();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
